ldpc_qc_encoder: RTL
====================

LDPC_QC_ENCODER -- requirements
Module: ldpc_qc_encoder

Interface
REQ-001 Parameter Z, default 360: circulant size; parity bits per block; generator row width.
REQ-002 Parameter KG, default 12: info groups per block; block carries K = Z*KG info bits.
REQ-003 Parameter ACC_EN, default 1: 1 = final parity accumulation p[i] = s[i] ^ p[i-1]; 0 = raw XOR sums.
REQ-004 Parameter ROM_INIT, default "gen_rom.mem": generator row image, KG rows of Z bits.
REQ-005 clk  in  1  sole clock, rising edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 s_valid  in  1  info bit offered.
REQ-008 s_data  in  1  info bit value.
REQ-009 s_ready  out  1  block accepts info bit; transfer = s_valid & s_ready.
REQ-010 m_valid  out  1  parity bit offered.
REQ-011 m_data  out  1  parity bit value.
REQ-012 m_last  out  1  marks final parity bit (index Z-1) of block.
REQ-013 m_ready  in  1  downstream accepts; transfer = m_valid & m_ready.
REQ-014 busy  out  1  high whenever state is not S_IN or an info block is partially received.

Function
REQ-015 FSM states S_INIT, S_IN, S_OUT; reset enters S_INIT.
REQ-016 S_INIT lasts exactly 2 cycles: ROM address 0 presented, row 0 loaded into row register; then S_IN.
REQ-017 S_IN: s_ready=1; each transfer with s_data=1 SHALL XOR row register into Z-bit sum register; s_data=0 leaves sum unchanged.
REQ-018 Each S_IN transfer SHALL rotate row register right by one (new[Z-1]=old[0]) except on last bit of a group.
REQ-019 Bit counter (0..Z-1) and group counter (0..KG-1) advance only on transfers; no advance while s_valid=0.
REQ-020 ROM is synchronous, 1-cycle read; ROM address SHALL become g+1 on first transfer of group g; row register loads ROM output (row g+1, unrotated) on last transfer of group g.
REQ-021 Last transfer of group KG-1 SHALL move FSM to S_OUT; sum update from that bit included; s_ready=0 from next cycle.
REQ-022 S_OUT emits Z parity bits in index order 0..Z-1; m_data registered, presented with m_valid the cycle after S_OUT entry.
REQ-023 m_data for index i = sum[i] ^ (ACC_EN ? p[i-1] : 0), p[-1]=0.
REQ-024 m_valid, m_data, m_last SHALL hold stable while m_valid=1 and m_ready=0; next index presented the cycle after each transfer.
REQ-025 m_last=1 only with index Z-1; on its transfer, sum and counters clear, m_valid drops next cycle, FSM returns to S_INIT.
REQ-026 s_ready=0 in S_INIT and S_OUT; back-to-back blocks separated by exactly the 2-cycle S_INIT gap.
REQ-027 Counters sized $clog2(Z) and $clog2(KG) bits; no wrap beyond Z-1 / KG-1.

Reset
REQ-028 rst=1 at any clock edge, including mid-block or mid-output, SHALL discard partial work: sum=0, counters=0, row register=0, ROM address=0, FSM=S_INIT.
REQ-029 Reset values: s_ready=0, m_valid=0, m_data=0, m_last=0, busy=1.

Structure
REQ-030 Package ldpc_enc_pkg SHALL hold state encoding typedef and default Z, KG constants.
REQ-031 Sub-module qc_gen_rom SHALL wrap generator memory (KG x Z, 1-cycle registered read, ROM_INIT load); all other logic in ldpc_qc_encoder.

Verification (Z=8, KG=2, row0=8'h01, row1=8'h03)
REQ-032 16 zero info bits, m_ready=1 -> 8 parity bits all 0, m_last on 8th only.
REQ-033 Bit0=1 rest 0, ACC_EN=0 -> parity 1,0,0,0,0,0,0,0; ACC_EN=1 -> eight 1s.
REQ-034 Bit1=1 only (row0 rotated once = 8'h80), ACC_EN=0 -> only index 7 = 1; bit8=1 only -> indices 0,1 = 1.
REQ-035 m_ready held 0 for 5 cycles at index 3 -> m_data/m_last unchanged, no index skipped or repeated.
REQ-036 rst pulsed after 5 info bits, then full block of bit0=1 -> output equals REQ-033 result, no contamination.
REQ-037 s_valid held 1 across two blocks -> s_ready low during S_OUT plus 2 S_INIT cycles, second block parity correct.

Source files
------------

// File: rtl/ldpc_enc_pkg.sv
// Shared definitions for the quasi-cyclic LDPC encoder: FSM encoding,
// default code dimensions and a counter-width helper.
package ldpc_enc_pkg;

  typedef enum logic [1:0] {
    S_INIT = 2'd0,
    S_IN   = 2'd1,
    S_OUT  = 2'd2
  } enc_state_e;

  localparam int DEF_Z  = 360;
  localparam int DEF_KG = 12;

  // Width of a counter spanning 0..n-1, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/qc_gen_rom.sv
// Generator-row memory: KG rows of Z bits with a one-cycle registered read.
// ROM_INIT names the image file of the build flow; contents come from ROM_IMAGE.
module qc_gen_rom
  import ldpc_enc_pkg::*;
#(
  parameter int              Z         = DEF_Z,
  parameter int              KG        = DEF_KG,
  parameter string           ROM_INIT  = "gen_rom.mem",
  parameter logic [Z*KG-1:0] ROM_IMAGE = '0,
  localparam int             AW        = cnt_w(KG)
) (
  input  logic          clk_i,
  input  logic [AW-1:0] addr_i,
  output logic [Z-1:0]  data_o
);

  logic [Z-1:0] mem_s [KG];
  logic [Z-1:0] data_q;

  for (genvar g = 0; g < KG; g++) begin : g_row
    assign mem_s[g] = ROM_IMAGE[g*Z +: Z];
  end

  // Registered read port.
  always_ff @(posedge clk_i) begin
    data_q <= mem_s[addr_i];
  end

  assign data_o = data_q;

endmodule

// File: rtl/ldpc_qc_encoder.sv
// Bit-serial QC-LDPC parity encoder: accumulates rotated generator rows for
// each '1' info bit, then streams Z parity bits (optionally prefix-XORed).
module ldpc_qc_encoder
  import ldpc_enc_pkg::*;
#(
  parameter int              Z         = DEF_Z,
  parameter int              KG        = DEF_KG,
  parameter int              ACC_EN    = 1,
  parameter string           ROM_INIT  = "gen_rom.mem",
  parameter logic [Z*KG-1:0] ROM_IMAGE = '0
) (
  input  logic clk,
  input  logic rst,
  input  logic s_valid,
  input  logic s_data,
  output logic s_ready,
  output logic m_valid,
  output logic m_data,
  output logic m_last,
  input  logic m_ready,
  output logic busy
);

  localparam int             BW       = cnt_w(Z);
  localparam int             GW       = cnt_w(KG);
  localparam logic [BW-1:0]  BIT_LAST = BW'(Z - 1);
  localparam logic [GW-1:0]  GRP_LAST = GW'(KG - 1);

  enc_state_e    state_q, state_d;
  logic          init_q, init_d;
  logic [Z-1:0]  row_q, row_d;
  logic [Z-1:0]  sum_q, sum_d;
  logic [BW-1:0] bit_q, bit_d;
  logic [GW-1:0] grp_q, grp_d;
  logic [GW-1:0] addr_q, addr_d;
  logic          m_valid_q, m_valid_d;
  logic          m_data_q, m_data_d;
  logic          m_last_q, m_last_d;
  logic [Z-1:0]  rom_data_s;
  logic          p_prev_s, p_next_s;

  qc_gen_rom #(
    .Z         (Z),
    .KG        (KG),
    .ROM_INIT  (ROM_INIT),
    .ROM_IMAGE (ROM_IMAGE)
  ) u_rom (
    .clk_i  (clk),
    .addr_i (addr_q),
    .data_o (rom_data_s)
  );

  // In S_OUT bit_q is reused as the index of the next parity bit to present;
  // the presented bit doubles as p[i-1] for the running accumulation.
  assign p_prev_s = ((ACC_EN != 0) && m_valid_q) ? m_data_q : 1'b0;
  assign p_next_s = sum_q[bit_q] ^ p_prev_s;

  // Next-state and datapath update.
  always_comb begin
    state_d   = state_q;
    init_d    = init_q;
    row_d     = row_q;
    sum_d     = sum_q;
    bit_d     = bit_q;
    grp_d     = grp_q;
    addr_d    = addr_q;
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    m_last_d  = m_last_q;
    case (state_q)
      S_INIT: begin
        if (init_q == 1'b0) begin
          init_d = 1'b1;
        end else begin
          init_d  = 1'b0;
          row_d   = rom_data_s;
          state_d = S_IN;
        end
      end
      S_IN: begin
        if (s_valid) begin
          if (s_data) begin
            sum_d = sum_q ^ row_q;
          end else begin
            sum_d = sum_q;
          end
          // Prefetch the next group's row early; it is consumed on the group's last bit.
          if (bit_q == '0) begin
            addr_d = (grp_q == GRP_LAST) ? '0 : grp_q + 1'b1;
          end else begin
            addr_d = addr_q;
          end
          if (bit_q == BIT_LAST) begin
            bit_d = '0;
            row_d = rom_data_s;
            if (grp_q == GRP_LAST) begin
              grp_d   = '0;
              state_d = S_OUT;
            end else begin
              grp_d = grp_q + 1'b1;
            end
          end else begin
            bit_d = bit_q + 1'b1;
            row_d = {row_q[0], row_q[Z-1:1]};
          end
        end else begin
          sum_d = sum_q;
        end
      end
      S_OUT: begin
        if (!m_valid_q || (m_ready && !m_last_q)) begin
          m_valid_d = 1'b1;
          m_data_d  = p_next_s;
          m_last_d  = (bit_q == BIT_LAST);
          bit_d     = (bit_q == BIT_LAST) ? bit_q : bit_q + 1'b1;
        end else if (m_ready) begin
          m_valid_d = 1'b0;
          m_data_d  = 1'b0;
          m_last_d  = 1'b0;
          sum_d     = '0;
          bit_d     = '0;
          grp_d     = '0;
          addr_d    = '0;
          state_d   = S_INIT;
        end else begin
          m_valid_d = m_valid_q;
        end
      end
      default: begin
        state_d = S_INIT;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_INIT;
      init_q    <= 1'b0;
      row_q     <= '0;
      sum_q     <= '0;
      bit_q     <= '0;
      grp_q     <= '0;
      addr_q    <= '0;
      m_valid_q <= 1'b0;
      m_data_q  <= 1'b0;
      m_last_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      init_q    <= init_d;
      row_q     <= row_d;
      sum_q     <= sum_d;
      bit_q     <= bit_d;
      grp_q     <= grp_d;
      addr_q    <= addr_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      m_last_q  <= m_last_d;
    end
  end

  assign s_ready = (state_q == S_IN);
  assign busy    = (state_q != S_IN) || (bit_q != '0) || (grp_q != '0);
  assign m_valid = m_valid_q;
  assign m_data  = m_data_q;
  assign m_last  = m_last_q;

endmodule
